// File: rtl/uart_tx_controller_if.sv
// ---------------------------------------------------------------------------
// uart_tx_controller_if
// Byte handshake between an upstream producer and uart_tx_controller.
//   tx_valid_i : producer has a byte to send
//   tx_data_i  : byte to send (DATA_BITS wide), sampled only on accept
//   tx_ready_o : controller can accept a byte
// Modports: master = producer side, slave = controller side.
// ---------------------------------------------------------------------------
interface uart_tx_controller_if #(
    parameter int DATA_BITS = 8
);
    logic                 tx_valid_i;
    logic [DATA_BITS-1:0] tx_data_i;
    logic                 tx_ready_o;

    modport master (
        output tx_valid_i,
        output tx_data_i,
        input  tx_ready_o
    );

    modport slave (
        input  tx_valid_i,
        input  tx_data_i,
        output tx_ready_o
    );
endinterface

// File: rtl/uart_tx_controller.sv
// ---------------------------------------------------------------------------
// uart_tx_controller
// Sequencer in front of the UART transmit output mux. Accepts a byte over a
// valid/ready handshake, shifts it out LSB-first through a PISO register and
// steers the mux through start, data, (parity) and stop bits, each held for
// CLKS_PER_BIT clocks.
//
// Ports:
//   clk          system clock, rising edge
//   n_rst        asynchronous active-low reset
//   bus (slave)  tx_valid_i / tx_data_i / tx_ready_o handshake
//   select_o     mux select: 00 start, 01 data, 10 parity, 11 stop/idle
//   piso_o       current data bit (shift register bit 0)
//   parity_o     parity of the latched byte
//   start_bit_o  constant 0
//   stop_bit_o   constant 1
//   busy_o       frame in progress
//   tx_done_o    one-cycle pulse on the final STOP cycle
//
// Build option: define UART_TX_PARITY_EN to include the parity bit. Without
// it the frame goes DATA -> STOP, parity_o is 0 and PARITY_ODD has no effect.
// ---------------------------------------------------------------------------
module uart_tx_controller #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_ODD   = 0
) (
    input  logic                  clk,
    input  logic                  n_rst,
    uart_tx_controller_if.slave   bus,
    output logic [1:0]            select_o,
    output logic                  piso_o,
    output logic                  parity_o,
    output logic                  start_bit_o,
    output logic                  stop_bit_o,
    output logic                  busy_o,
    output logic                  tx_done_o
);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    // Reject illegal configurations at elaboration time.
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx_controller: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
        $error("uart_tx_controller: DATA_BITS must be 5..9");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
        $error("uart_tx_controller: PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [BAUD_W-1:0]     r_baud_cnt;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  w_bit_end;
    logic                  w_accept;
    logic                  w_ready;

    assign w_bit_end   = (r_baud_cnt == BAUD_LAST);
    // Ready is only high in IDLE, so accept implies IDLE.
    assign w_accept    = w_ready && bus.tx_valid_i;
    assign bus.tx_ready_o = w_ready;
    assign piso_o      = r_shift[0];
    assign start_bit_o = 1'b0;
    assign stop_bit_o  = 1'b1;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        select_o     = 2'b11;
        w_ready      = 1'b0;
        busy_o       = 1'b1;
        tx_done_o    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                busy_o  = 1'b0;
                if (bus.tx_valid_i) begin
                    w_next_state = S_START;
                end
            end
            S_START: begin
                select_o = 2'b00;
                if (w_bit_end) begin
                    w_next_state = S_DATA;
                end
            end
            S_DATA: begin
                select_o = 2'b01;
                if (w_bit_end && (r_bit_cnt == BIT_LAST)) begin
`ifdef UART_TX_PARITY_EN
                    w_next_state = S_PARITY;
`else
                    w_next_state = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                select_o = 2'b10;
                if (w_bit_end) begin
                    w_next_state = S_STOP;
                end
            end
`endif
            S_STOP: begin
                select_o = 2'b11;
                if (w_bit_end) begin
                    tx_done_o    = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Baud/bit counters and the PISO register. The baud counter rests at 0
    // in IDLE so every state after accept lasts exactly CLKS_PER_BIT cycles.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
        end else if (w_accept) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= bus.tx_data_i;
        end else if (r_state != S_IDLE) begin
            r_baud_cnt <= w_bit_end ? '0 : r_baud_cnt + 1'b1;
            if (r_state == S_DATA && w_bit_end) begin
                r_shift   <= r_shift >> 1;
                r_bit_cnt <= (r_bit_cnt == BIT_LAST) ? '0 : r_bit_cnt + 1'b1;
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    logic r_parity;

    // Parity is captured once per accept and held for the whole frame.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_parity <= (^bus.tx_data_i) ^ 1'(PARITY_ODD);
        end
    end

    assign parity_o = r_parity;
`else
    assign parity_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_controller.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_controller
// Self-checking bench for uart_tx_controller (CLKS_PER_BIT=4, DATA_BITS=8).
// Expected frames come from a bit-list model: start, data LSB-first,
// optional parity, stop, each bit expanded to CLKS_PER_BIT cycles.
// ---------------------------------------------------------------------------
module tb_uart_tx_controller;
    localparam int CPB = 4;
    localparam int DB  = 8;
`ifdef UART_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int MAXF = (DB + 3) * CPB;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    uart_tx_controller_if #(.DATA_BITS(DB)) bus_a ();
    uart_tx_controller_if #(.DATA_BITS(DB)) bus_b ();

    logic [1:0] sel_a, sel_b;
    logic piso_a, par_a, start_a, stop_a, busy_a, done_a;
    logic piso_b, par_b, start_b, stop_b, busy_b, done_b;

    uart_tx_controller #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY_ODD(0)) dut_a (
        .clk(clk), .n_rst(n_rst), .bus(bus_a),
        .select_o(sel_a), .piso_o(piso_a), .parity_o(par_a),
        .start_bit_o(start_a), .stop_bit_o(stop_a), .busy_o(busy_a), .tx_done_o(done_a)
    );

    uart_tx_controller #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY_ODD(1)) dut_b (
        .clk(clk), .n_rst(n_rst), .bus(bus_b),
        .select_o(sel_b), .piso_o(piso_b), .parity_o(par_b),
        .start_bit_o(start_b), .stop_bit_o(stop_b), .busy_o(busy_b), .tx_done_o(done_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int   exp_sel  [MAXF];
    logic exp_piso [MAXF];
    bit   piso_chk [MAXF];
    logic exp_par;
    int   exp_len;

    function automatic void model_frame(input logic [DB-1:0] d, input int odd);
        int nb;
        int idx;
        nb      = DB + 2 + PAR_BITS;
        exp_len = nb * CPB;
        exp_par = (PAR_BITS != 0) ? ((^d) ^ odd[0]) : 1'b0;
        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < CPB; k++) begin
                idx = b * CPB + k;
                piso_chk[idx] = 1'b0;
                exp_piso[idx] = 1'b0;
                if (b == 0) begin
                    exp_sel[idx] = 0;
                end else if (b <= DB) begin
                    exp_sel[idx]  = 1;
                    exp_piso[idx] = d[b-1];
                    piso_chk[idx] = 1'b1;
                end else if (b == DB + 1 && PAR_BITS != 0) begin
                    exp_sel[idx] = 2;
                end else begin
                    exp_sel[idx] = 3;
                end
            end
        end
    endfunction

    // Present a byte and wait (bounded) for the accept edge; returns at the
    // first START cycle. With hold=1 valid is left asserted.
    task automatic send(input logic [DB-1:0] d, input bit hold);
        int t;
        t = 0;
        bus_a.tx_valid_i = 1'b1;
        bus_a.tx_data_i  = d;
        while (bus_a.tx_ready_o !== 1'b1 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        n_checks++;
        if (t >= 200) begin
            n_fail++;
            $display("FAIL send_timeout: ready=%b after %0d cycles, required 1", bus_a.tx_ready_o, t);
        end
        @(posedge clk); #1;
        if (!hold) bus_a.tx_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({sel_a, busy_a, bus_a.tx_ready_o, done_a, piso_a, par_a, start_a, stop_a} !== 9'b11_0_1_0_0_0_0_1) begin
            n_fail++;
            $display("FAIL reset_a: sel/busy/rdy/done/piso/par/start/stop=%b required 110100001",
                     {sel_a, busy_a, bus_a.tx_ready_o, done_a, piso_a, par_a, start_a, stop_a});
        end
        n_checks++;
        if ({sel_b, busy_b, bus_b.tx_ready_o, done_b, piso_b, par_b} !== 7'b11_0_1_0_0_0) begin
            n_fail++;
            $display("FAIL reset_b: sel/busy/rdy/done/piso/par=%b required 1101000",
                     {sel_b, busy_b, bus_b.tx_ready_o, done_b, piso_b, par_b});
        end
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_frames();
        logic [DB-1:0] d;
        for (int f = 0; f < 4; f++) begin
            d = (f == 0) ? 8'hA5 : DB'($urandom_range(0, 255));
            model_frame(d, 0);
            send(d, 1'b0);
            for (int c = 0; c < exp_len; c++) begin
                logic [5:0] ev;
                ev = {2'(exp_sel[c]), 1'b1, 1'b0, (c == exp_len - 1), exp_par};
                n_checks++;
                if ({sel_a, busy_a, bus_a.tx_ready_o, done_a, par_a} !== ev) begin
                    n_fail++;
                    $display("FAIL frame_ctl data=%h cyc %0d: sel/busy/rdy/done/par=%b required %b",
                             d, c + 1, {sel_a, busy_a, bus_a.tx_ready_o, done_a, par_a}, ev);
                end
                if (piso_chk[c]) begin
                    n_checks++;
                    if (piso_a !== exp_piso[c]) begin
                        n_fail++;
                        $display("FAIL frame_piso data=%h cyc %0d: piso=%b required %b", d, c + 1, piso_a, exp_piso[c]);
                    end
                end
                @(posedge clk); #1;
            end
            n_checks++;
            if ({sel_a, busy_a, bus_a.tx_ready_o, done_a} !== 5'b11_0_1_0) begin
                n_fail++;
                $display("FAIL frame_idle data=%h: sel/busy/rdy/done=%b required 11010",
                         d, {sel_a, busy_a, bus_a.tx_ready_o, done_a});
            end
        end
    endtask

    task automatic test_parity();
        logic [DB-1:0] d;
        logic pa, pb;
        for (int f = 0; f < 3; f++) begin
            d = (f == 0) ? 8'h07 : DB'($urandom_range(0, 255));
            model_frame(d, 1);
            pb = exp_par;
            model_frame(d, 0);
            pa = exp_par;
            bus_a.tx_valid_i = 1'b1; bus_a.tx_data_i = d;
            bus_b.tx_valid_i = 1'b1; bus_b.tx_data_i = d;
            @(posedge clk); #1;
            bus_a.tx_valid_i = 1'b0; bus_b.tx_valid_i = 1'b0;
            bus_a.tx_data_i = ~d;    bus_b.tx_data_i = ~d;
            n_checks++;
            if ({par_a, par_b} !== {pa, pb}) begin
                n_fail++;
                $display("FAIL parity data=%h: even/odd parity=%b%b required %b%b", d, par_a, par_b, pa, pb);
            end
            repeat (exp_len) @(posedge clk);
            #1;
            n_checks++;
            if ({busy_a, busy_b, par_a, par_b} !== {2'b00, pa, pb}) begin
                n_fail++;
                $display("FAIL parity_hold data=%h: busy_a/busy_b/par_a/par_b=%b required %b",
                         d, {busy_a, busy_b, par_a, par_b}, {2'b00, pa, pb});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [DB-1:0] d;
        send(8'h01, 1'b1);
        for (int f = 0; f < 2; f++) begin
            d = (f == 0) ? 8'h01 : 8'h80;
            model_frame(d, 0);
            for (int c = 0; c < exp_len; c++) begin
                logic [5:0] ev;
                ev = {2'(exp_sel[c]), 1'b1, 1'b0, (c == exp_len - 1), exp_par};
                n_checks++;
                if ({sel_a, busy_a, bus_a.tx_ready_o, done_a, par_a} !== ev) begin
                    n_fail++;
                    $display("FAIL b2b_ctl data=%h cyc %0d: sel/busy/rdy/done/par=%b required %b",
                             d, c + 1, {sel_a, busy_a, bus_a.tx_ready_o, done_a, par_a}, ev);
                end
                if (piso_chk[c]) begin
                    n_checks++;
                    if (piso_a !== exp_piso[c]) begin
                        n_fail++;
                        $display("FAIL b2b_piso data=%h cyc %0d: piso=%b required %b", d, c + 1, piso_a, exp_piso[c]);
                    end
                end
                @(posedge clk); #1;
            end
            n_checks++;
            if ({sel_a, busy_a, bus_a.tx_ready_o, done_a} !== 5'b11_0_1_0) begin
                n_fail++;
                $display("FAIL b2b_gap data=%h: sel/busy/rdy/done=%b required 11010",
                         d, {sel_a, busy_a, bus_a.tx_ready_o, done_a});
            end
            if (f == 0) begin
                bus_a.tx_data_i = 8'h80;
                @(posedge clk); #1;
                bus_a.tx_valid_i = 1'b0;
            end
        end
        for (int c = 0; c < 2 * CPB; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (busy_a !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_no_extra cyc %0d: busy=%b required 0", c, busy_a);
            end
        end
    endtask

    task automatic test_busy_ignore();
        model_frame(8'h00, 0);
        send(8'h00, 1'b0);
        for (int c = 0; c < exp_len; c++) begin
            logic [5:0] ev;
            ev = {2'(exp_sel[c]), 1'b1, 1'b0, (c == exp_len - 1), exp_par};
            n_checks++;
            if ({sel_a, busy_a, bus_a.tx_ready_o, done_a, par_a} !== ev) begin
                n_fail++;
                $display("FAIL busy_ctl cyc %0d: sel/busy/rdy/done/par=%b required %b",
                         c + 1, {sel_a, busy_a, bus_a.tx_ready_o, done_a, par_a}, ev);
            end
            if (piso_chk[c]) begin
                n_checks++;
                if (piso_a !== exp_piso[c]) begin
                    n_fail++;
                    $display("FAIL busy_piso cyc %0d: piso=%b required %b", c + 1, piso_a, exp_piso[c]);
                end
            end
            if (c == 2 * CPB + 1) begin
                bus_a.tx_valid_i = 1'b1; bus_a.tx_data_i = 8'hFF;
            end else if (c == 2 * CPB + 2) begin
                bus_a.tx_valid_i = 1'b0;
            end
            @(posedge clk); #1;
        end
        for (int c = 0; c < 3 * CPB; c++) begin
            n_checks++;
            if ({busy_a, sel_a} !== 3'b0_11) begin
                n_fail++;
                $display("FAIL busy_no_extra cyc %0d: busy/sel=%b required 011", c, {busy_a, sel_a});
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        logic [DB-1:0] d;
        d = DB'($urandom_range(0, 255)) | 8'h01;
        send(d, 1'b0);
        repeat (4 * CPB + 1) @(posedge clk);
        #2 n_rst = 1'b0;
        #1;
        n_checks++;
        if ({sel_a, busy_a, bus_a.tx_ready_o, done_a, piso_a, par_a} !== 7'b11_0_1_0_0_0) begin
            n_fail++;
            $display("FAIL reset_mid: sel/busy/rdy/done/piso/par=%b required 1101000",
                     {sel_a, busy_a, bus_a.tx_ready_o, done_a, piso_a, par_a});
        end
        for (int c = 0; c < 2 * CPB; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({done_a, busy_a} !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_hold cyc %0d: done/busy=%b required 00", c, {done_a, busy_a});
            end
        end
        n_rst = 1'b1;
        @(posedge clk); #1;
        d = DB'($urandom_range(0, 255));
        model_frame(d, 0);
        send(d, 1'b0);
        for (int c = 0; c < exp_len; c++) begin
            logic [5:0] ev;
            ev = {2'(exp_sel[c]), 1'b1, 1'b0, (c == exp_len - 1), exp_par};
            n_checks++;
            if ({sel_a, busy_a, bus_a.tx_ready_o, done_a, par_a} !== ev) begin
                n_fail++;
                $display("FAIL post_reset_ctl data=%h cyc %0d: sel/busy/rdy/done/par=%b required %b",
                         d, c + 1, {sel_a, busy_a, bus_a.tx_ready_o, done_a, par_a}, ev);
            end
            if (piso_chk[c]) begin
                n_checks++;
                if (piso_a !== exp_piso[c]) begin
                    n_fail++;
                    $display("FAIL post_reset_piso data=%h cyc %0d: piso=%b required %b", d, c + 1, piso_a, exp_piso[c]);
                end
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if ({sel_a, busy_a, bus_a.tx_ready_o} !== 4'b11_0_1) begin
            n_fail++;
            $display("FAIL post_reset_idle: sel/busy/rdy=%b required 1101", {sel_a, busy_a, bus_a.tx_ready_o});
        end
    endtask

    initial begin
        bus_a.tx_valid_i = 1'b0;
        bus_a.tx_data_i  = '0;
        bus_b.tx_valid_i = 1'b0;
        bus_b.tx_data_i  = '0;
        test_reset();
        test_frames();
        test_parity();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
